fc_redundant_ctrl: RTL and testbench
====================================

Name: fc_redundant_ctrl

Overview:
- Parametrised fault-countermeasure sequencer placed between the top-level encryption request and one Ascon Encryption core instance.
- Runs the core RUNS times on the same key/nonce/AD/PT and captures cipher text and tag from every run.
- Releases the result only if all runs agree. On mismatch or core timeout it flags a fault and suppresses the output.
- Generalises the earlier two-core encrypt/decrypt wrapper to N temporal-redundant runs, with a timeout watchdog and a saturating fault counter.

Parameters:
- Y, 40, cipher text width in bits
- TAG_W, 128, tag width in bits
- RUNS, 2, number of redundant core runs (legal 2..8)
- TIMEOUT, 1023, maximum cycles from core_start to core_done before a timeout fault
- FCNT_W, 8, width of the saturating fault counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse; accepted only in IDLE
- core_start  out  1  one-cycle launch pulse to the Encryption core
- core_done  in  1  one-cycle pulse from the core when ct/tag are valid
- core_ct  in  Y  core cipher text, sampled on core_done
- core_tag  in  TAG_W  core tag, sampled on core_done
- rnd_mask  in  Y+TAG_W  fresh random word (used by the optional feature)
- busy  out  1  high from the cycle after start acceptance until valid
- valid  out  1  one-cycle completion pulse
- fault  out  1  valid-qualified fault flag; held until next accepted start
- fault_cause  out  2  00 none, 01 mismatch, 10 timeout
- ct_out  out  Y  released cipher text
- tag_out  out  TAG_W  released tag
- fault_count  out  FCNT_W  saturating count of faulted operations

Behaviour:
- The interface is decided: one clock, named clk; reset named rst, synchronous, active-high.
- Reset values:
  - All outputs are 0, including fault_count.
  - State is IDLE.
  - Run counter, timeout counter and capture registers are 0.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - start=1 moves to LAUNCH.
  - Run index clears to 0.
  - fault and fault_cause clear.
  - busy rises next cycle.
- LAUNCH: core_start=1 for exactly this cycle; timeout counter clears; next state WAIT.
- WAIT:
  - Timeout counter increments each cycle.
  - On core_done with run index 0, capture core_ct/core_tag as the reference.
  - On core_done with run index >0, compare against the reference; any difference sets a sticky mismatch bit.
  - After the done, if run index < RUNS-1: increment the index and go to LAUNCH. Otherwise go to DONE.
  - If the counter reaches TIMEOUT without core_done: set the timeout bit and go to DONE directly.
  - core_done and the timeout terminal count in the same cycle: core_done wins.
- DONE (one cycle):
  - valid=1 and busy=0 from this cycle; next state IDLE.
  - Clean run: ct_out/tag_out = reference; fault=0; fault_cause=00.
  - Faulted run: ct_out/tag_out = 0; fault=1; fault_cause = 10 if timeout, else 01; fault_count increments, saturating at all-ones.
  - ct_out/tag_out hold their value until the next DONE.
- Latency, no fault: start accepted at cycle t, core_start at t+1, and each run adds (core latency + 1) cycles. valid asserts the cycle after the last core_done.
- start outside IDLE is ignored with no queueing. core_done outside WAIT is ignored.
- rst mid-operation: immediate return to IDLE; core_start is never left high; fault_count resets.
- Timeout counter width is clog2(TIMEOUT+1).

Optional Feature:
- Macro: FC_INFECTIVE_EN.
- Defined: on a fault, {ct_out, tag_out} = reference XOR rnd_mask sampled in DONE. A random-looking output denies an attacker a differential; fault and fault_cause behave unchanged.
- Undefined: faulted outputs are zeroed as above, and rnd_mask is unused.

Decomposition:
- Shared package fc_pkg holds:
  - state encoding typedef (IDLE, LAUNCH, WAIT, DONE)
  - fault_cause constants FC_NONE, FC_MISMATCH, FC_TIMEOUT
  - clog2-based width helper
- One natural sub-module, fc_watchdog: timeout counter with clear and terminal-count output.
- Compare and capture logic stay inline.

Test Plan:
- Clean run, RUNS=2, core model with 10-cycle latency, ct=40'h12_3456_789A, tag=128'hA5A5 repeated → two core_start pulses; valid at cycle t+23; fault=0; outputs equal the model values.
- Second run flips ct bit 0 (40'h12_3456_789B) → valid with fault=1, fault_cause=01, ct_out=0, tag_out=0, fault_count=1.
- Core never asserts core_done, TIMEOUT=15 → valid at t+17 with fault_cause=10; only one core_start issued.
- FC_INFECTIVE_EN defined with a tag mismatch, rnd_mask=all 0x5A → {ct_out,tag_out} = reference XOR mask; fault=1.
- start pulsed in WAIT, then rst asserted mid-WAIT → second start ignored; after rst all outputs 0, state IDLE, and a new start runs cleanly.
- FCNT_W=2, four faulted operations → fault_count reads 1, 2, 3, 3 (saturates).

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types for the redundant-run fault countermeasure: FSM encoding, fault causes
// and a counter-width helper.
package fc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } fc_state_e;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_MISMATCH = 2'b01;
   localparam logic [1:0] FC_TIMEOUT  = 2'b10;

   // Bits needed to hold max_val; never less than one.
   function automatic int fc_cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/fc_watchdog.sv
// Core-response watchdog: counts enabled cycles since clear, tc_o flags the TIMEOUT-th cycle.
// Combinational terminal count, no backpressure; the count freezes at terminal.
module fc_watchdog
   import fc_pkg::*;
#(
   parameter int TIMEOUT = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int CW = fc_cnt_w(TIMEOUT);
   localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Terminal on the TIMEOUT-th waiting cycle, so a done in that same cycle still counts.
   assign tc_o = en_i && (cnt_q == TC_VAL);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fc_redundant_ctrl.sv
// Runs the encryption core RUNS times and releases ct/tag only if every run agrees; valid one cycle after the last done.
// start is taken only in IDLE (no queueing); FC_INFECTIVE_EN masks faulted output with rnd_mask instead of zeroing.
module fc_redundant_ctrl
   import fc_pkg::*;
#(
   parameter int Y       = 40,
   parameter int TAG_W   = 128,
   parameter int RUNS    = 2,
   parameter int TIMEOUT = 1023,
   parameter int FCNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 core_start,
   input  logic                 core_done,
   input  logic [Y-1:0]         core_ct,
   input  logic [TAG_W-1:0]     core_tag,
   input  logic [Y+TAG_W-1:0]   rnd_mask,
   output logic                 busy,
   output logic                 valid,
   output logic                 fault,
   output logic [1:0]           fault_cause,
   output logic [Y-1:0]         ct_out,
   output logic [TAG_W-1:0]     tag_out,
   output logic [FCNT_W-1:0]    fault_count
);

   localparam int DW = Y + TAG_W;
   localparam int IW = fc_cnt_w(RUNS - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(RUNS - 1);

   fc_state_e         state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DW-1:0]     ref_q, ref_d;
   logic [DW-1:0]     out_q, out_d;
   logic              mism_q, mism_d;
   logic              tmo_q, tmo_d;
   logic              fault_q, fault_d;
   logic [1:0]        cause_q, cause_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;

   logic              wd_clr, wd_en, wd_tc;
   logic [DW-1:0]     core_dat, fault_dat, release_dat;

   assign core_dat = {core_ct, core_tag};

`ifdef FC_INFECTIVE_EN
   assign fault_dat = ref_q ^ rnd_mask;
`else
   logic unused_rnd_mask;
   assign unused_rnd_mask = ^rnd_mask;
   assign fault_dat       = '0;
`endif

   assign release_dat = fault_q ? fault_dat : ref_q;

   fc_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk   (clk),
      .rst   (rst),
      .clr_i (wd_clr),
      .en_i  (wd_en),
      .tc_o  (wd_tc)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ref_d   = ref_q;
      out_d   = out_q;
      mism_d  = mism_q;
      tmo_d   = tmo_q;
      fault_d = fault_q;
      cause_d = cause_q;
      fcnt_d  = fcnt_q;
      wd_clr  = 1'b0;
      wd_en   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LAUNCH;
               idx_d   = '0;
               ref_d   = '0;
               mism_d  = 1'b0;
               tmo_d   = 1'b0;
               fault_d = 1'b0;
               cause_d = FC_NONE;
            end
         end
         ST_LAUNCH: begin
            wd_clr  = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            wd_en = 1'b1;
            if (core_done) begin
               if (idx_q == '0) begin
                  ref_d = core_dat;
               end else if (core_dat != ref_q) begin
                  mism_d = 1'b1;
               end
               if (idx_q != LAST_IDX) begin
                  idx_d   = idx_q + IW'(1);
                  state_d = ST_LAUNCH;
               end else begin
                  state_d = ST_DONE;
               end
            end else if (wd_tc) begin
               tmo_d   = 1'b1;
               state_d = ST_DONE;
            end
            // Verdict is registered on entry so it is already visible during DONE.
            if ((state_d == ST_DONE) && (mism_d || tmo_d)) begin
               fault_d = 1'b1;
               cause_d = tmo_d ? FC_TIMEOUT : FC_MISMATCH;
               if (fcnt_q != '1) begin
                  fcnt_d = fcnt_q + FCNT_W'(1);
               end
            end
         end
         ST_DONE: begin
            out_d   = release_dat;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         ref_q   <= '0;
         out_q   <= '0;
         mism_q  <= 1'b0;
         tmo_q   <= 1'b0;
         fault_q <= 1'b0;
         cause_q <= FC_NONE;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ref_q   <= ref_d;
         out_q   <= out_d;
         mism_q  <= mism_d;
         tmo_q   <= tmo_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign core_start          = (state_q == ST_LAUNCH);
   assign busy                = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
   assign valid               = (state_q == ST_DONE);
   assign fault               = fault_q;
   assign fault_cause         = cause_q;
   assign fault_count         = fcnt_q;
   assign {ct_out, tag_out}   = (state_q == ST_DONE) ? release_dat : out_q;

endmodule

// File: tb/tb_fc_redundant_ctrl.sv
// Scoreboard bench: a stimulus process plans each operation, predicts its outcome and queues it;
// a monitor compares whenever valid rises, and also checks that released data holds between results.
module tb_fc_redundant_ctrl;

   localparam int Y       = 40;
   localparam int TAG_W   = 128;
   localparam int RUNS    = 2;
   localparam int TIMEOUT = 15;
   localparam int FCNT_W  = 2;
   localparam int DW      = Y + TAG_W;
   localparam int FMAX    = (1 << FCNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst, start, core_start, core_done;
   logic [Y-1:0]      core_ct;
   logic [TAG_W-1:0]  core_tag;
   logic [DW-1:0]     rnd_mask;
   logic              busy, valid, fault;
   logic [1:0]        fault_cause;
   logic [Y-1:0]      ct_out;
   logic [TAG_W-1:0]  tag_out;
   logic [FCNT_W-1:0] fault_count;

   fc_redundant_ctrl #(
      .Y(Y), .TAG_W(TAG_W), .RUNS(RUNS), .TIMEOUT(TIMEOUT), .FCNT_W(FCNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .core_start(core_start),
      .core_done(core_done), .core_ct(core_ct), .core_tag(core_tag),
      .rnd_mask(rnd_mask), .busy(busy), .valid(valid), .fault(fault),
      .fault_cause(fault_cause), .ct_out(ct_out), .tag_out(tag_out),
      .fault_count(fault_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] ref_dat;
      bit            flt;
      logic [1:0]    cause;
      int            fcnt;
      int            lat;
      int            t0;
      int            nlaunch;
   } exp_t;

   exp_t          sb_q[$];
   int            checks, errors;
   int            cyc;
   int            model_fcnt;
   bit            op_active, noise_en, mask_fixed;
   int            plan_lat[8];
   logic [DW-1:0] plan_dat[8];
   int            run_ptr, launches, remaining;
   bit            pending;
   logic [DW-1:0] pend_dat, last_out;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] rand_dat();
      return DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Core model: answers each core_start after the planned latency; may inject stray dones when idle.
   initial begin
      core_done = 1'b0; core_ct = '0; core_tag = '0;
      pending = 1'b0; launches = 0; run_ptr = 0; remaining = 0; pend_dat = '0;
      forever begin
         @(negedge clk);
         core_done = 1'b0;
         if (rst) begin
            pending = 1'b0;
         end else begin
            if (pending) begin
               remaining--;
               if (remaining == 0) begin
                  core_done = 1'b1;
                  {core_ct, core_tag} = pend_dat;
                  pending = 1'b0;
               end
            end else if (noise_en && !op_active && $urandom_range(0, 3) == 0) begin
               core_done = 1'b1;
               {core_ct, core_tag} = rand_dat();
            end
            if (core_start && run_ptr < 8) begin
               launches++;
               pend_dat  = plan_dat[run_ptr];
               remaining = plan_lat[run_ptr];
               pending   = 1'b1;
               run_ptr++;
            end
         end
      end
   end

   // Mask changes just after the rising edge so it is stable for the monitor and for capture.
   initial begin
      rnd_mask = '0;
      forever begin
         @(posedge clk);
         #1;
         rnd_mask = mask_fixed ? {21{8'h5A}} : rand_dat();
      end
   end

   // Monitor
   initial begin
      exp_t          e;
      logic [DW-1:0] exp_out;
      last_out = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_out = '0;
            continue;
         end
         if (valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got valid=1 expected no result pending");
            end else begin
               e = sb_q.pop_front();
`ifdef FC_INFECTIVE_EN
               exp_out = e.flt ? (e.ref_dat ^ rnd_mask) : e.ref_dat;
`else
               exp_out = e.flt ? '0 : e.ref_dat;
`endif
               check("ct_tag", {ct_out, tag_out}, exp_out);
               check("fault", DW'(fault), DW'(e.flt));
               check("fault_cause", DW'(fault_cause), DW'(e.cause));
               check("fault_count", DW'(fault_count), DW'(e.fcnt));
               check("latency", DW'(cyc - e.t0), DW'(e.lat));
               check("core_starts", DW'(launches), DW'(e.nlaunch));
               check("busy_at_valid", DW'(busy), DW'(0));
            end
            last_out  = {ct_out, tag_out};
            op_active = 1'b0;
         end else begin
            check("hold", {ct_out, tag_out}, last_out);
         end
      end
   end

   // Predict the outcome of the current plan from the run rules, then launch it.
   task automatic start_op(input bit extra_start);
      exp_t e;
      int   k, sum;
      bit   mism;
      k = -1; sum = 0; mism = 1'b0;
      for (int i = 0; i < RUNS; i++) begin
         if (plan_lat[i] > TIMEOUT) begin
            k = i;
            break;
         end
         sum += plan_lat[i] + 1;
         if (plan_dat[i] != plan_dat[0]) mism = 1'b1;
      end
      e.ref_dat = (k == 0) ? '0 : plan_dat[0];
      e.flt     = (k >= 0) || mism;
      e.cause   = (k >= 0) ? 2'b10 : (mism ? 2'b01 : 2'b00);
      e.lat     = (k >= 0) ? (1 + sum + TIMEOUT + 1) : (1 + sum);
      e.nlaunch = (k >= 0) ? (k + 1) : RUNS;
      if (e.flt) model_fcnt = (model_fcnt < FMAX) ? model_fcnt + 1 : FMAX;
      e.fcnt    = model_fcnt;
      e.t0      = cyc;
      sb_q.push_back(e);
      run_ptr   = 0;
      launches  = 0;
      op_active = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (extra_start) begin
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (!op_active && !pending) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_done: got no valid within 3000 cycles expected completion");
         sb_q.delete();
         op_active = 1'b0;
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"}, DW'(valid), DW'(0));
      check({tag, "_busy"}, DW'(busy), DW'(0));
      check({tag, "_core_start"}, DW'(core_start), DW'(0));
      check({tag, "_fault"}, DW'(fault), DW'(0));
      check({tag, "_cause"}, DW'(fault_cause), DW'(0));
      check({tag, "_ct_tag"}, {ct_out, tag_out}, DW'(0));
      check({tag, "_fcnt"}, DW'(fault_count), DW'(0));
   endtask

   task automatic set_pair(input int l0, input int l1, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      plan_lat[0] = l0; plan_lat[1] = l1;
      plan_dat[0] = d0; plan_dat[1] = d1;
   endtask

   initial begin
      logic [DW-1:0] base, flip;
      int            b;
      checks = 0; errors = 0; cyc = 0; model_fcnt = 0;
      op_active = 1'b0; noise_en = 1'b0; mask_fixed = 1'b0;
      rst = 1'b1; start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         plan_lat[i] = 1;
         plan_dat[i] = '0;
      end
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      base = {40'h12_3456_789A, {8{16'hA5A5}}};
      set_pair(10, 10, base, base);
      start_op(1'b0); wait_done();

      set_pair(10, 10, base, {40'h12_3456_789B, {8{16'hA5A5}}});
      start_op(1'b0); wait_done();

      set_pair(300, 10, base, base);
      start_op(1'b0); wait_done();

      // Tag mismatch with a fixed mask.
      mask_fixed = 1'b1;
      flip = base;
      flip[5] = ~flip[5];
      set_pair(7, 7, base, flip);
      start_op(1'b0); wait_done();
      mask_fixed = 1'b0;

      // Done on the terminal-count cycle wins; one cycle later is a timeout on the second run.
      set_pair(TIMEOUT, TIMEOUT, base, base);
      start_op(1'b1); wait_done();
      set_pair(1, TIMEOUT + 1, base, base);
      start_op(1'b0); wait_done();

      // Reset mid-WAIT with an ignored second start.
      set_pair(12, 12, base, base);
      start_op(1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      sb_q.delete();
      op_active = 1'b0;
      model_fcnt = 0;
      repeat (2) @(negedge clk);
      check_idle_outputs("midrst");
      rst = 1'b0;
      @(negedge clk);
      set_pair(4, 9, rand_dat(), '0);
      plan_dat[1] = plan_dat[0];
      start_op(1'b0); wait_done();

      // Four faulted operations walk the small counter into saturation.
      for (int n = 0; n < 4; n++) begin
         base = rand_dat();
         flip = base;
         b = $urandom_range(0, DW - 1);
         flip[b] = ~flip[b];
         if (n == 2) set_pair($urandom_range(1, 9), 300, base, base);
         else        set_pair($urandom_range(1, 9), $urandom_range(1, 9), base, flip);
         start_op(1'b0); wait_done();
      end

      noise_en = 1'b1;
      for (int n = 0; n < 40; n++) begin
         base = rand_dat();
         for (int i = 0; i < RUNS; i++) begin
            plan_lat[i] = ($urandom_range(0, 7) == 0) ? 300 : $urandom_range(1, 18);
            plan_dat[i] = base;
            if (i > 0 && $urandom_range(0, 2) == 0) begin
               b = $urandom_range(0, DW - 1);
               plan_dat[i][b] = ~plan_dat[i][b];
            end
         end
         start_op($urandom_range(0, 1) == 1);
         wait_done();
      end
      noise_en = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not reach its end");
      $fatal(1);
   end

endmodule
